// File: rtl/mpc_shared_ram_arb.sv
// mpc_shared_ram_arb: N-port Avalon-MM shared RAM. A round-robin arbiter with
// an optional per-port lock grants one access per cycle to a single-port
// synchronous RAM. Read data comes back one cycle after the grant.

// Per-port read return: shows fresh RAM data on its valid cycle and otherwise
// holds the last value returned to this port.
module mpc_shared_ram_ret #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] hold_q;

    // capture each returned word so readdata stays put between strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   hold_q <= '0;
        else if (vld_i) hold_q <= data_i;
    end

    assign rdata_o = vld_i ? data_i : hold_q;
endmodule

module mpc_shared_ram_arb #(
    parameter int    NUM_PORTS  = 5,
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 14,
    parameter int    LOCK_MAX   = 16,
    parameter string INIT_FILE  = "mpc_shared_ram.hex"
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  avs_address,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] avs_byteenable,
    input  logic [NUM_PORTS-1:0]             avs_read,
    input  logic [NUM_PORTS-1:0]             avs_write,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  avs_writedata,
    input  logic [NUM_PORTS-1:0]             avs_lock,
    output logic [NUM_PORTS-1:0]             avs_waitrequest,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  avs_readdata,
    output logic [NUM_PORTS-1:0]             avs_readdatavalid
);
    localparam int BE    = DATA_WIDTH / 8;
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW    = $clog2(LOCK_MAX + 1);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);
    localparam logic [PW-1:0] LAST_RST   = PW'(NUM_PORTS - 1);

    // per-port views of the flattened buses
    logic [ADDR_WIDTH-1:0] addr_a [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdat_a [NUM_PORTS];
    logic [BE-1:0]         be_a   [NUM_PORTS];
    logic [NUM_PORTS-1:0]  req;

    // arbiter state
    logic [PW-1:0] last_q, last_d;
    logic          lk_vld_q, lk_vld_d;
    logic [PW-1:0] lk_own_q, lk_own_d;
    logic [CW-1:0] lk_cnt_q, lk_cnt_d;

    logic                 lock_hit;
    logic                 gnt_vld;
    logic [PW-1:0]        gnt_idx;
    logic [NUM_PORTS-1:0] gnt;

    // granted access
    logic                  g_we, g_re;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wd;
    logic [BE-1:0]         g_be;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [NUM_PORTS-1:0]  rvld_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign addr_a[gi] = avs_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdat_a[gi] = avs_writedata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign be_a[gi]   = avs_byteenable[gi*BE +: BE];
            assign gnt[gi]    = gnt_vld && (gnt_idx == PW'(gi));

            mpc_shared_ram_ret #(.DATA_WIDTH(DATA_WIDTH)) u_ret (
                .clk     (clk),
                .reset_n (reset_n),
                .vld_i   (rvld_q[gi]),
                .data_i  (ram_q),
                .rdata_o (avs_readdata[gi*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    assign req = avs_read | avs_write;

    // grant select: a live lock wins outright, otherwise first requester after last_grant
    always_comb begin
        lock_hit = reset_n && lk_vld_q && req[lk_own_q] && (lk_cnt_q < LOCK_MAX_C);
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        if (lock_hit) begin
            gnt_vld = 1'b1;
            gnt_idx = lk_own_q;
        end else if (reset_n) begin
            // walk downwards so the nearest port after last_grant is assigned last
            for (int k = NUM_PORTS; k >= 1; k--) begin
                if (req[(int'(last_q) + k) % NUM_PORTS]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PW'((int'(last_q) + k) % NUM_PORTS);
                end
            end
        end
    end

    assign g_addr = addr_a[gnt_idx];
    assign g_wd   = wdat_a[gnt_idx];
    assign g_be   = be_a[gnt_idx];
    assign g_we   = gnt_vld && avs_write[gnt_idx];
    assign g_re   = gnt_vld && avs_read[gnt_idx] && !avs_write[gnt_idx];

    // arbiter next state: track last winner and the length of the current locked run
    always_comb begin
        last_d   = last_q;
        lk_vld_d = lk_vld_q;
        lk_own_d = lk_own_q;
        lk_cnt_d = lk_cnt_q;
        if (!gnt_vld) begin
            lk_vld_d = 1'b0;
            lk_cnt_d = '0;
        end else begin
            last_d = gnt_idx;
            if (avs_lock[gnt_idx]) begin
                lk_vld_d = 1'b1;
                if (lock_hit) begin
                    lk_cnt_d = lk_cnt_q + 1'b1;
                end else begin
                    // fresh run, also after a run was cut off at LOCK_MAX
                    lk_own_d = gnt_idx;
                    lk_cnt_d = CW'(1);
                end
            end else begin
                lk_vld_d = 1'b0;
                lk_cnt_d = '0;
            end
        end
    end

    // arbiter state registers; last_grant resets to the top port so port 0 wins first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q   <= LAST_RST;
            lk_vld_q <= 1'b0;
            lk_own_q <= '0;
            lk_cnt_q <= '0;
        end else begin
            last_q   <= last_d;
            lk_vld_q <= lk_vld_d;
            lk_own_q <= lk_own_d;
            lk_cnt_q <= lk_cnt_d;
        end
    end

    // single-port RAM: byte-lane write, registered read; never written while in reset
    always_ff @(posedge clk) begin
        if (g_we) begin
            for (int b = 0; b < BE; b++) begin
                if (g_be[b]) mem[g_addr][b*8 +: 8] <= g_wd[b*8 +: 8];
            end
        end
        ram_q <= mem[g_addr];
    end

    // read return strobe goes to the port that won the read; reset cancels it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rvld_q <= '0;
        else          rvld_q <= gnt & {NUM_PORTS{g_re}};
    end

    assign avs_readdatavalid = rvld_q;
    assign avs_waitrequest   = reset_n ? (req & ~gnt) : {NUM_PORTS{1'b1}};
endmodule
